// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: bus commands, FSM states,
// default I/O addresses and the address-decode region type.
package mem_responder_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [8:0] LED_ADDR_DFLT = 9'h100;
    localparam logic [8:0] SW_ADDR_DFLT  = 9'h140;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_LED,
        RGN_SW,
        RGN_NONE
    } region_e;

    // True for the two commands that start an access; 2'b11 behaves as MNONE.
    function automatic logic is_access(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_responder_sync_ram.sv
// Single-port RAM with write enable and a registered, read-enabled output.
// Contents are not reset; the read register holds its value between reads.
module mem_responder_sync_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 256,
    parameter int unsigned AW     = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and one-cycle registered read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a CPU request in IDLE, waits WAIT_STATES
// cycles in BUSY, then completes the RAM / LED / switch access with a
// one-cycle mem_rdy in DONE.
// Optional feature macro: MEM_OOR_ERR_EN (drives mem_err on unmapped access).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned RAM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(LED_ADDR_DFLT),
    parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(SW_ADDR_DFLT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [7:0]        sw,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_rdy,
    output logic [7:0]        led,
    output logic              mem_err
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              wr_q,     wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [7:0]        led_q,    led_d;
    logic [DATA_W-1:0] rd_q,     rd_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rdy_q,    rdy_d;

    logic              ram_we_c;
    logic              ram_re_c;
    logic [DATA_W-1:0] ram_rdata;
    region_e           rgn_c;
    logic              access_c;

    // Decode the latched address into a target region.
    always_comb begin
        rgn_c = RGN_NONE;
        if (!addr_q[ADDR_W-1]) begin
            rgn_c = RGN_RAM;
        end else if (addr_q == LED_ADDR) begin
            rgn_c = RGN_LED;
        end else if (addr_q == SW_ADDR) begin
            rgn_c = RGN_SW;
        end
    end

    // The BUSY cycle with an expired wait counter is where the access happens.
    assign access_c = (state_q == ST_BUSY) && (cnt_q == '0);

    // Next-state, request latch and completion logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        led_d    = led_q;
        rd_d     = rd_q;
        rd_sel_d = rd_sel_q;
        rdy_d    = 1'b0;
        ram_we_c = 1'b0;
        ram_re_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_access(mem_cmd)) begin
                    wr_d    = (mem_cmd == MWRITE);
                    addr_d  = mem_addr;
                    wdata_d = write_data;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                    case (rgn_c)
                        RGN_RAM: begin
                            if (wr_q) begin
                                ram_we_c = 1'b1;
                            end else begin
                                ram_re_c = 1'b1;
                                rd_sel_d = 1'b1;
                            end
                        end
                        RGN_LED: begin
                            if (wr_q) begin
                                led_d = wdata_q[7:0];
                            end else begin
                                rd_d     = DATA_W'(led_q);
                                rd_sel_d = 1'b0;
                            end
                        end
                        RGN_SW: begin
                            if (!wr_q) begin
                                rd_d     = DATA_W'(sw);
                                rd_sel_d = 1'b0;
                            end
                        end
                        default: begin
                            if (!wr_q) begin
                                rd_d     = '0;
                                rd_sel_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            led_q    <= '0;
            rd_q     <= '0;
            rd_sel_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            led_q    <= led_d;
            rd_q     <= rd_d;
            rd_sel_q <= rd_sel_d;
            rdy_q    <= rdy_d;
        end
    end

    mem_responder_sync_ram #(
        .DATA_W (DATA_W),
        .WORDS  (RAM_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_c),
        .re_i    (ram_re_c),
        .addr_i  (addr_q[RAM_AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // RAM loads come straight from the RAM output register; I/O loads from rd_q.
    assign read_data = rd_sel_q ? ram_rdata : rd_q;
    assign mem_rdy   = rdy_q;
    assign led       = led_q;

`ifdef MEM_OOR_ERR_EN
    logic err_q;

    // Flag unmapped addresses and stores to the read-only switch port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access_c && ((rgn_c == RGN_NONE) || ((rgn_c == RGN_SW) && wr_q));
        end
    end

    assign mem_err = err_q;
`else
    logic unused_access;
    assign unused_access = access_c;
    assign mem_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT_STATES = 1).
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  sw;
    logic [15:0] read_data;
    logic        mem_rdy;
    logic [7:0]  led;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

`ifdef MEM_OOR_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .sw         (sw),
        .read_data  (read_data),
        .mem_rdy    (mem_rdy),
        .led        (led),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access: drive at a negedge, drop the command, scramble the bus while
    // busy, and report data/err/latency (in negedges) seen with mem_rdy.
    task automatic access(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                          output logic [15:0] rdata, output logic err, output int lat);
        @(negedge clk);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            mem_cmd    = MNONE;
            mem_addr   = 9'h0AA;
            write_data = 16'hDEAD;
        end while (!mem_rdy && lat < 20);
        rdata = read_data;
        err   = mem_err;
        @(negedge clk);
        check("rdy_one_cycle", 32'(mem_rdy), 32'd0);
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    logic [11:0] rdy_bits;

    initial begin
        reset      = 1'b1;
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        sw         = 8'h3C;

        // Reset state
        @(negedge clk);
        check("rst_read_data", 32'(read_data), 32'h0);
        check("rst_mem_rdy",   32'(mem_rdy),   32'h0);
        check("rst_led",       32'(led),       32'h0);
        check("rst_mem_err",   32'(mem_err),   32'h0);
        reset = 1'b0;

        // RAM write then read back
        access(MWRITE, 9'h010, 16'hBEEF, rd, er, lat);
        check("wr010_lat", 32'(lat), 32'd3);
        access(MREAD, 9'h010, 16'h0000, rd, er, lat);
        check("rd010_lat",  32'(lat), 32'd3);
        check("rd010_data", 32'(rd),  32'hBEEF);
        check("rd010_err",  32'(er),  32'h0);

        // LED write, LED readback, switch read
        access(MWRITE, 9'h100, 16'h12A5, rd, er, lat);
        check("led_lat", 32'(lat), 32'd3);
        check("led_val", 32'(led), 32'hA5);
        check("led_wr_holds_rdata", 32'(read_data), 32'hBEEF);
        access(MREAD, 9'h100, 16'h0000, rd, er, lat);
        check("led_rd_data", 32'(rd), 32'h00A5);
        access(MREAD, 9'h140, 16'h0000, rd, er, lat);
        check("sw_lat",  32'(lat), 32'd3);
        check("sw_data", 32'(rd),  32'h003C);
        check("sw_err",  32'(er),  32'h0);

        // Reset during BUSY of a write drops the write
        access(MWRITE, 9'h005, 16'h1111, rd, er, lat);
        @(negedge clk);
        mem_cmd    = MWRITE;
        mem_addr   = 9'h005;
        write_data = 16'h2222;
        @(negedge clk);
        mem_cmd = MNONE;
        reset   = 1'b1;
        @(negedge clk);
        check("midrst_led",   32'(led),       32'h0);
        check("midrst_rdata", 32'(read_data), 32'h0);
        reset  = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(mem_rdy);
        end
        check("midrst_no_rdy", 32'(pulses), 32'd0);
        access(MREAD, 9'h005, 16'h0000, rd, er, lat);
        check("midrst_ram5", 32'(rd), 32'h1111);

        // Back-to-back reads with address wiggled during BUSY
        access(MWRITE, 9'h001, 16'h0101, rd, er, lat);
        access(MWRITE, 9'h002, 16'h0202, rd, er, lat);
        @(negedge clk);
        mem_cmd  = MREAD;
        mem_addr = 9'h001;
        rdy_bits = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            rdy_bits[i-1] = mem_rdy;
            if (mem_rdy) check("b2b_data", 32'(read_data), 32'h0101);
            mem_addr = (i == 4) ? 9'h001 : 9'h002;
            if (i >= 8) mem_cmd = MNONE;
        end
        check("b2b_rdy_pattern", 32'(rdy_bits), 32'h044);

        // Unmapped read and switch-port write
        access(MREAD, 9'h1FF, 16'h0000, rd, er, lat);
        check("oor_lat",  32'(lat), 32'd3);
        check("oor_data", 32'(rd),  32'h0);
        check("oor_err",  32'(er),  32'(EXP_ERR));
        access(MWRITE, 9'h140, 16'h00FF, rd, er, lat);
        check("swwr_lat", 32'(lat), 32'd3);
        check("swwr_err", 32'(er),  32'(EXP_ERR));
        check("swwr_led", 32'(led), 32'h0);

        // Command 2'b11 is a no-op
        @(negedge clk);
        mem_cmd = 2'b11;
        pulses  = 0;
        repeat (10) begin
            @(negedge clk);
            pulses += int'(mem_rdy);
        end
        mem_cmd = MNONE;
        check("cmd11_no_rdy", 32'(pulses),    32'd0);
        check("cmd11_rdata",  32'(read_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
